// File: rtl/fifo_to_sram_pkg.sv
// Shared types for the FIFO-to-SRAM transfer controller.
// Holds the controller state encoding and the data path width.
package fifo_to_sram_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LATCH,
    START,
    WAIT_DONE
  } state_t;

endpackage

// File: rtl/fifo_to_sram_ctrl.sv
// Drains the sample FIFO into the SRAM write engine one word at a time,
// starting a burst once the fill level reaches a programmable threshold.
module fifo_to_sram_ctrl
  import fifo_to_sram_pkg::*;
#(
  parameter int CNT_WIDTH = 5
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic                  empty,
  input  logic [CNT_WIDTH-1:0]  fifo_number_samples,
  input  logic [CNT_WIDTH-1:0]  fifo_number_samples_terminal,
  input  logic                  data_done,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  output logic                  pop,
  output logic [DATA_WIDTH-1:0] sram_data_out,
  output logic                  sram_start
);

  state_t state;
  logic   trigger;

  // Threshold of zero degenerates to "any data" via the unsigned compare.
  assign trigger = !empty &&
    (fifo_number_samples >= fifo_number_samples_terminal);

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state         <= IDLE;
      pop           <= 1'b0;
      sram_start    <= 1'b0;
      sram_data_out <= '0;
    end else begin
      pop        <= 1'b0;
      sram_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trigger) begin
            state <= POP;
            pop   <= 1'b1;
          end
        end
        POP: begin
          state <= LATCH;
        end
        LATCH: begin
          sram_data_out <= fifo_data_in;
          sram_start    <= 1'b1;
          state         <= START;
        end
        START: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // Burst runs until empty; threshold is not re-checked here.
          if (data_done) begin
            if (!empty) begin
              state <= POP;
              pop   <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_to_sram_ctrl.sv
// Randomized scoreboard bench for fifo_to_sram_ctrl with a queue-based
// FIFO model and an automatic SRAM-engine done responder.
module tb_fifo_to_sram_ctrl;

  localparam int CW = 5;

  logic          wb_clk = 1'b0;
  logic          wb_rst = 1'b0;
  logic          empty = 1'b1;
  logic [CW-1:0] fifo_num = '0;
  logic [CW-1:0] term = '0;
  logic          data_done = 1'b0;
  logic [31:0]   fifo_data_in = '0;
  logic          pop;
  logic [31:0]   sram_data_out;
  logic          sram_start;

  fifo_to_sram_ctrl #(.CNT_WIDTH(CW)) dut (
    .wb_clk                       (wb_clk),
    .wb_rst                       (wb_rst),
    .empty                        (empty),
    .fifo_number_samples          (fifo_num),
    .fifo_number_samples_terminal (term),
    .data_done                    (data_done),
    .fifo_data_in                 (fifo_data_in),
    .pop                          (pop),
    .sram_data_out                (sram_data_out),
    .sram_start                   (sram_start)
  );

  always #5 wb_clk = ~wb_clk;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  int          delay_q[$];

  logic        push_req = 1'b0;
  logic [31:0] push_data = '0;
  logic        auto_done = 1'b0;
  logic        busy = 1'b0;
  int          pop_cnt = 0;
  int          starts = 0;
  int          total_pushed = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Registered-output FIFO: read data appears the edge after pop.
  always @(posedge wb_clk) begin
    if (pop) begin
      chk("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
      if (fifo_q.size() != 0) fifo_data_in <= fifo_q.pop_front();
    end
    if (push_req) fifo_q.push_back(push_data);
    empty    <= (fifo_q.size() == 0);
    fifo_num <= CW'(fifo_q.size());
  end

  // Scoreboard monitor.
  logic [31:0] prev_out = '0;
  logic        prev_pop = 1'b0;
  always @(negedge wb_clk) begin
    if (!wb_rst) begin
      prev_out = '0;
      prev_pop = 1'b0;
    end else begin
      if (sram_start) begin
        starts++;
        if (exp_q.size() == 0)
          chk("unexpected_start", 32'd1, 32'd0);
        else
          chk("sram_data", sram_data_out, exp_q.pop_front());
      end else begin
        chk("data_stable", sram_data_out, prev_out);
      end
      if (pop) chk("pop_width", 32'(prev_pop), 32'd0);
      if (pop && !prev_pop) pop_cnt++;
      prev_out = sram_data_out;
      prev_pop = pop;
    end
  end

  // SRAM engine stand-in: answers each start with a delayed done pulse.
  always begin
    int  d;
    logic exp_pop;
    @(negedge wb_clk);
    if (wb_rst && auto_done && sram_start) begin
      busy = 1'b1;
      d = (delay_q.size() != 0) ? delay_q.pop_front()
                                : int'($urandom_range(1, 6));
      repeat (d) @(negedge wb_clk);
      data_done = 1'b1;
      exp_pop = !empty;
      @(negedge wb_clk);
      data_done = 1'b0;
      chk("pop_after_done", 32'(pop), 32'(exp_pop));
      busy = 1'b0;
    end
  end

  task automatic push_word(input logic [31:0] w);
    @(negedge wb_clk);
    push_req = 1'b1;
    push_data = w;
    exp_q.push_back(w);
    total_pushed++;
    @(negedge wb_clk);
    push_req = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 12 && n < 600) begin
      @(negedge wb_clk);
      n++;
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !busy &&
          !push_req && !pop && !sram_start)
        quiet++;
      else
        quiet = 0;
    end
    chk({name, "_drain_timeout"}, 32'(quiet >= 12), 32'd1);
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (!sram_start && n < 50) begin
      @(negedge wb_clk);
      n++;
    end
    chk({name, "_start_timeout"}, 32'(sram_start), 32'd1);
  endtask

  initial begin
    int base;
    int n;
    int t;
    logic [31:0] words[5];
    words[0] = 32'hA5B6C7D8;
    words[1] = 32'hE9FA0123;
    words[2] = 32'h4567890A;
    words[3] = 32'h55555555;
    words[4] = 32'hAAAAAAAA;

    // Reset
    repeat (3) @(negedge wb_clk);
    chk("rst_pop", 32'(pop), 32'd0);
    chk("rst_start", 32'(sram_start), 32'd0);
    chk("rst_data", sram_data_out, 32'd0);
    wb_rst = 1'b1;
    repeat (5) @(negedge wb_clk);
    chk("idle_empty_no_pop", 32'(pop_cnt), 32'd0);

    // Threshold plus ordered drain with fixed done delays
    term = CW'(4);
    auto_done = 1'b1;
    for (int i = 2; i <= 10; i += 2) delay_q.push_back(i);
    for (int i = 0; i < 3; i++) push_word(words[i]);
    repeat (15) @(negedge wb_clk);
    chk("below_term_no_pop", 32'(pop_cnt), 32'd0);
    push_word(words[3]);
    n = 0;
    while (pop_cnt == 0 && n < 10) begin
      @(negedge wb_clk);
      n++;
    end
    chk("term_pop", 32'(pop_cnt), 32'd1);
    push_word(words[4]);
    wait_drain("ordered");
    chk("ordered_pops", 32'(pop_cnt), 32'd5);
    chk("ordered_starts", 32'(starts), 32'd5);
    chk("ordered_empty", 32'(empty), 32'd1);

    // Stray done in IDLE
    base = pop_cnt;
    @(negedge wb_clk);
    data_done = 1'b1;
    @(negedge wb_clk);
    data_done = 1'b0;
    repeat (8) @(negedge wb_clk);
    chk("stray_idle_pop", 32'(pop_cnt), 32'(base));

    // Stray done in START must not release WAIT_DONE
    auto_done = 1'b0;
    term = '0;
    push_word($urandom);
    wait_start("stray");
    data_done = 1'b1;
    @(negedge wb_clk);
    data_done = 1'b0;
    base = pop_cnt;
    push_word($urandom);
    repeat (8) @(negedge wb_clk);
    chk("stray_start_pop", 32'(pop_cnt), 32'(base));
    data_done = 1'b1;
    @(negedge wb_clk);
    data_done = 1'b0;
    auto_done = 1'b1;
    chk("real_done_pop", 32'(pop), 32'd1);
    wait_drain("stray");

    // Mid-burst reset in WAIT_DONE
    auto_done = 1'b0;
    term = CW'(4);
    for (int i = 0; i < 4; i++) push_word($urandom);
    wait_start("rstburst");
    repeat (2) @(negedge wb_clk);
    #2 wb_rst = 1'b0;
    #1;
    chk("async_rst_pop", 32'(pop), 32'd0);
    chk("async_rst_start", 32'(sram_start), 32'd0);
    chk("async_rst_data", sram_data_out, 32'd0);
    @(negedge wb_clk);
    @(negedge wb_clk);
    wb_rst = 1'b1;
    base = pop_cnt;
    repeat (20) @(negedge wb_clk);
    chk("post_rst_wait_term", 32'(pop_cnt), 32'(base));
    auto_done = 1'b1;
    push_word($urandom);
    wait_drain("post_rst");

    // Randomized bursts
    for (int it = 0; it < 12; it++) begin
      t = int'($urandom_range(0, 6));
      n = int'($urandom_range(1, 8));
      if (n < t) n = t;
      term = CW'(t);
      base = pop_cnt;
      for (int i = 0; i < n; i++) begin
        if (i > 0 && i < t)
          chk("rand_below_term", 32'(pop_cnt), 32'(base));
        repeat ($urandom_range(0, 3)) @(negedge wb_clk);
        push_word($urandom);
      end
      wait_drain("rand");
    end

    chk("start_count", 32'(starts), 32'(total_pushed));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
